// File: rtl/rob_pkg.sv
// Shared types and default widths for the reorder-buffer commit path.
package rob_pkg;

  localparam int ROB_INDEX_WIDTH = 5;
  localparam int ROB_DATA_WIDTH  = 32;
  localparam int ROB_AREG_WIDTH  = 5;
  localparam int ROB_DEPTH       = 1 << ROB_INDEX_WIDTH;

  // One ROB entry as seen by the retire logic.
  typedef struct packed {
    logic                      done;
    logic                      wr_en;
    logic [ROB_AREG_WIDTH-1:0] areg;
    logic [ROB_DATA_WIDTH-1:0] value;
    logic                      is_store;
    logic                      mispredict;
    logic                      exc;
    logic [ROB_DATA_WIDTH-1:0] pc;
    logic [ROB_DATA_WIDTH-1:0] target;
  } rob_entry_t;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_RECOVER = 2'd2
  } commit_state_e;

endpackage

// File: rtl/commit_perf_cnt.sv
// Saturating retire/flush/store-stall event counters for the commit controller.
// Only instantiated when ROB_COMMIT_PERF_EN is defined.
module commit_perf_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  comcnt_i,
  input  logic        flush_entry_i,
  input  logic        st_stall_i,
  output logic [31:0] perf_retired_o,
  output logic [15:0] perf_flush_o,
  output logic [31:0] perf_st_stall_o
);

  logic [31:0] r_retired;
  logic [15:0] r_flush;
  logic [31:0] r_st_stall;
  logic [32:0] w_retired_sum;

  assign w_retired_sum = {1'b0, r_retired} + {31'd0, comcnt_i};

  // Counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retired  <= '0;
      r_flush    <= '0;
      r_st_stall <= '0;
    end else begin
      r_retired <= w_retired_sum[32] ? '1 : w_retired_sum[31:0];
      if (flush_entry_i && (r_flush != '1)) begin
        r_flush <= r_flush + 16'd1;
      end
      if (st_stall_i && (r_st_stall != '1)) begin
        r_st_stall <= r_st_stall + 32'd1;
      end
    end
  end

  assign perf_retired_o  = r_retired;
  assign perf_flush_o    = r_flush;
  assign perf_st_stall_o = r_st_stall;

endmodule

// File: rtl/rob_commit_ctrl.sv
// Retire-side controller for the reorder buffer: retires up to two head
// entries per cycle, drives ARF writes and the store-commit handshake, and
// sequences precise flushes (RUN -> FLUSH -> RECOVER -> RUN).
// Optional perf counters are enabled by defining ROB_COMMIT_PERF_EN.
module rob_commit_ctrl
  import rob_pkg::*;
#(
  parameter int INDEX_WIDTH = ROB_INDEX_WIDTH,
  parameter int DATA_WIDTH  = ROB_DATA_WIDTH,
  parameter int AREG_WIDTH  = ROB_AREG_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [INDEX_WIDTH-1:0] head_i,
  input  logic [INDEX_WIDTH:0]   count_i,
  output logic [INDEX_WIDTH-1:0] rd_idx0_o,
  output logic [INDEX_WIDTH-1:0] rd_idx1_o,
  input  rob_entry_t             e0_i,
  input  rob_entry_t             e1_i,
  output logic [1:0]             comcnt_o,
  output logic                   arf_we0_o,
  output logic                   arf_we1_o,
  output logic [AREG_WIDTH-1:0]  arf_waddr0_o,
  output logic [AREG_WIDTH-1:0]  arf_waddr1_o,
  output logic [DATA_WIDTH-1:0]  arf_wdata0_o,
  output logic [DATA_WIDTH-1:0]  arf_wdata1_o,
  output logic                   st_commit_valid_o,
  input  logic                   st_commit_ready_i,
  output logic                   flush_o,
  output logic [INDEX_WIDTH-1:0] flush_index_o,
  output logic [DATA_WIDTH-1:0]  redirect_pc_o,
  input  logic                   flush_ack_i
`ifdef ROB_COMMIT_PERF_EN
  ,
  output logic [31:0]            perf_retired_o,
  output logic [15:0]            perf_flush_o,
  output logic [31:0]            perf_st_stall_o
`endif
);

  localparam logic [INDEX_WIDTH-1:0] IDX_ONE = INDEX_WIDTH'(1);
  localparam logic [INDEX_WIDTH-1:0] IDX_TWO = INDEX_WIDTH'(2);

  commit_state_e          r_state;
  commit_state_e          w_state_next;
  logic                   r_flush;
  logic [INDEX_WIDTH-1:0] r_flush_index;
  logic [DATA_WIDTH-1:0]  r_redirect;

  logic                   w_has1, w_has2;
  logic                   w_e0_exc, w_c0, w_c1_base, w_c1;
  logic                   w_st0, w_st1;
  logic [1:0]             w_comcnt;
  logic                   w_we0, w_we1, w_stv;
  logic                   w_flush_trig;
  logic [INDEX_WIDTH-1:0] w_flush_index_next;
  logic [DATA_WIDTH-1:0]  w_redirect_next;

  assign rd_idx0_o = head_i;
  assign rd_idx1_o = head_i + IDX_ONE;

  // Slot qualification. The slot1 store candidate excludes the ready term so
  // the valid handshake never loops back through st_commit_ready_i.
  assign w_has1    = (count_i != '0);
  assign w_has2    = (count_i > (INDEX_WIDTH+1)'(1));
  assign w_e0_exc  = w_has1 & e0_i.done & e0_i.exc;
  assign w_c0      = w_has1 & e0_i.done & ~e0_i.exc & (~e0_i.is_store | st_commit_ready_i);
  assign w_c1_base = w_c0 & ~e0_i.mispredict & w_has2 & e1_i.done & ~e1_i.exc
                   & ~(e0_i.is_store & e1_i.is_store);
  assign w_c1      = w_c1_base & (~e1_i.is_store | st_commit_ready_i);
  assign w_st0     = w_has1 & e0_i.done & e0_i.is_store & ~e0_i.exc;
  assign w_st1     = w_c1_base & e1_i.is_store;

  // Next-state and retire decisions; FLUSH/RECOVER suppress all retirement.
  always_comb begin
    w_state_next       = r_state;
    w_comcnt           = 2'd0;
    w_we0              = 1'b0;
    w_we1              = 1'b0;
    w_stv              = 1'b0;
    w_flush_trig       = 1'b0;
    w_flush_index_next = r_flush_index;
    w_redirect_next    = r_redirect;
    case (r_state)
      ST_RUN: begin
        w_comcnt = {1'b0, w_c0} + {1'b0, w_c1};
        w_we0    = w_c0 & e0_i.wr_en & ~(w_c1 & e1_i.wr_en & (e1_i.areg == e0_i.areg));
        w_we1    = w_c1 & e1_i.wr_en;
        w_stv    = w_st0 | w_st1;
        if (w_e0_exc) begin
          w_flush_trig       = 1'b1;
          w_flush_index_next = head_i;
          w_redirect_next    = e0_i.pc;
        end else if (w_c0 & e0_i.mispredict) begin
          w_flush_trig       = 1'b1;
          w_flush_index_next = head_i + IDX_ONE;
          w_redirect_next    = e0_i.target;
        end else if (w_c1 & e1_i.mispredict) begin
          w_flush_trig       = 1'b1;
          w_flush_index_next = head_i + IDX_TWO;
          w_redirect_next    = e1_i.target;
        end
        if (w_flush_trig) begin
          w_state_next = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        w_state_next = ST_RECOVER;
      end
      ST_RECOVER: begin
        if (flush_ack_i) begin
          w_state_next = ST_RUN;
        end
      end
      default: begin
        w_state_next = ST_RUN;
      end
    endcase
  end

  // State, flush pulse and latched recovery target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_RUN;
      r_flush       <= 1'b0;
      r_flush_index <= '0;
      r_redirect    <= '0;
    end else begin
      r_state       <= w_state_next;
      r_flush       <= w_flush_trig;
      r_flush_index <= w_flush_index_next;
      r_redirect    <= w_redirect_next;
    end
  end

  assign comcnt_o          = w_comcnt;
  assign arf_we0_o         = w_we0;
  assign arf_we1_o         = w_we1;
  assign arf_waddr0_o      = w_we0 ? e0_i.areg  : '0;
  assign arf_waddr1_o      = w_we1 ? e1_i.areg  : '0;
  assign arf_wdata0_o      = w_we0 ? e0_i.value : '0;
  assign arf_wdata1_o      = w_we1 ? e1_i.value : '0;
  assign st_commit_valid_o = w_stv;
  assign flush_o           = r_flush;
  assign flush_index_o     = r_flush_index;
  assign redirect_pc_o     = r_redirect;

`ifdef ROB_COMMIT_PERF_EN
  commit_perf_cnt u_perf (
    .clk             (clk),
    .rst_n           (rst_n),
    .comcnt_i        (w_comcnt),
    .flush_entry_i   (w_flush_trig),
    .st_stall_i      ((r_state == ST_RUN) & w_stv & ~st_commit_ready_i),
    .perf_retired_o  (perf_retired_o),
    .perf_flush_o    (perf_flush_o),
    .perf_st_stall_o (perf_st_stall_o)
  );
`endif

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Directed testbench for rob_commit_ctrl with a scoreboard of expected values.
module tb_rob_commit_ctrl;
  import rob_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  head_i;
  logic [5:0]  count_i;
  logic [4:0]  rd_idx0_o, rd_idx1_o;
  rob_entry_t  e0_i, e1_i;
  logic [1:0]  comcnt_o;
  logic        arf_we0_o, arf_we1_o;
  logic [4:0]  arf_waddr0_o, arf_waddr1_o;
  logic [31:0] arf_wdata0_o, arf_wdata1_o;
  logic        st_commit_valid_o, st_commit_ready_i;
  logic        flush_o;
  logic [4:0]  flush_index_o;
  logic [31:0] redirect_pc_o;
  logic        flush_ack_i;
`ifdef ROB_COMMIT_PERF_EN
  logic [31:0] perf_retired_o, perf_st_stall_o;
  logic [15:0] perf_flush_o;
`endif

  always #5 clk = ~clk;

  rob_commit_ctrl dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .head_i            (head_i),
    .count_i           (count_i),
    .rd_idx0_o         (rd_idx0_o),
    .rd_idx1_o         (rd_idx1_o),
    .e0_i              (e0_i),
    .e1_i              (e1_i),
    .comcnt_o          (comcnt_o),
    .arf_we0_o         (arf_we0_o),
    .arf_we1_o         (arf_we1_o),
    .arf_waddr0_o      (arf_waddr0_o),
    .arf_waddr1_o      (arf_waddr1_o),
    .arf_wdata0_o      (arf_wdata0_o),
    .arf_wdata1_o      (arf_wdata1_o),
    .st_commit_valid_o (st_commit_valid_o),
    .st_commit_ready_i (st_commit_ready_i),
    .flush_o           (flush_o),
    .flush_index_o     (flush_index_o),
    .redirect_pc_o     (redirect_pc_o),
    .flush_ack_i       (flush_ack_i)
`ifdef ROB_COMMIT_PERF_EN
    ,
    .perf_retired_o    (perf_retired_o),
    .perf_flush_o      (perf_flush_o),
    .perf_st_stall_o   (perf_st_stall_o)
`endif
  );

  // Observable signal selectors for scoreboard entries.
  localparam int S_COMCNT = 0, S_WE0 = 1, S_WE1 = 2, S_WADDR0 = 3, S_WADDR1 = 4,
                 S_WDATA0 = 5, S_WDATA1 = 6, S_STV = 7, S_FLUSH = 8, S_FIDX = 9,
                 S_REDIR = 10, S_RIDX0 = 11, S_RIDX1 = 12;

  typedef struct {
    string       tag;
    int          sig;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic logic [31:0] observe(int sig);
    case (sig)
      S_COMCNT: return {30'd0, comcnt_o};
      S_WE0:    return {31'd0, arf_we0_o};
      S_WE1:    return {31'd0, arf_we1_o};
      S_WADDR0: return {27'd0, arf_waddr0_o};
      S_WADDR1: return {27'd0, arf_waddr1_o};
      S_WDATA0: return arf_wdata0_o;
      S_WDATA1: return arf_wdata1_o;
      S_STV:    return {31'd0, st_commit_valid_o};
      S_FLUSH:  return {31'd0, flush_o};
      S_FIDX:   return {27'd0, flush_index_o};
      S_REDIR:  return redirect_pc_o;
      S_RIDX0:  return {27'd0, rd_idx0_o};
      S_RIDX1:  return {27'd0, rd_idx1_o};
      default:  return 32'hdead_beef;
    endcase
  endfunction

  task automatic push(input string tag, input int sig, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.exp = exp;
    sb.push_back(e);
  endtask

  // Settle combinational outputs, then pop and compare every pending expectation.
  task automatic drain();
    exp_t        e;
    logic [31:0] o;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = observe(e.sig);
      checks++;
      assert (o === e.exp) else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, o, e.exp);
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic rob_entry_t mk(input logic done, input logic wr, input logic [4:0] areg,
                                    input logic [31:0] val, input logic st, input logic mp,
                                    input logic ex, input logic [31:0] pc, input logic [31:0] tgt);
    rob_entry_t e;
    e.done = done; e.wr_en = wr; e.areg = areg; e.value = val; e.is_store = st;
    e.mispredict = mp; e.exc = ex; e.pc = pc; e.target = tgt;
    return e;
  endfunction

  function automatic rob_entry_t alu(input logic [4:0] areg, input logic [31:0] val);
    return mk(1'b1, 1'b1, areg, val, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endfunction

  function automatic rob_entry_t store_e();
    return mk(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
  endfunction

  initial begin
    rst_n = 1'b0; head_i = '0; count_i = '0; st_commit_ready_i = 1'b0; flush_ack_i = 1'b0;
    e0_i = alu(5'd1, 32'h1); e1_i = alu(5'd2, 32'h2);
    #12;
    push("rst_flush", S_FLUSH, 0); push("rst_fidx", S_FIDX, 0); push("rst_redir", S_REDIR, 0);
    push("rst_comcnt", S_COMCNT, 0); push("rst_we0", S_WE0, 0); push("rst_stv", S_STV, 0);
    drain();
    @(negedge clk); rst_n = 1'b1;
    cyc();

    // Two independent ALU ops.
    head_i = 5'd4; count_i = 6'd2; e0_i = alu(5'd3, 32'hA); e1_i = alu(5'd5, 32'hB);
    push("dual_comcnt", S_COMCNT, 2); push("dual_we0", S_WE0, 1); push("dual_we1", S_WE1, 1);
    push("dual_waddr0", S_WADDR0, 3); push("dual_waddr1", S_WADDR1, 5);
    push("dual_wdata0", S_WDATA0, 32'hA); push("dual_ridx0", S_RIDX0, 4); push("dual_ridx1", S_RIDX1, 5);
    drain();

    // Only one valid entry.
    count_i = 6'd1;
    push("cnt1_comcnt", S_COMCNT, 1); push("cnt1_we1", S_WE1, 0);
    drain();

    // Same destination register: slot1 wins.
    count_i = 6'd2; e0_i = alu(5'd7, 32'h11); e1_i = alu(5'd7, 32'h22);
    push("waw_comcnt", S_COMCNT, 2); push("waw_we0", S_WE0, 0); push("waw_we1", S_WE1, 1);
    push("waw_wdata1", S_WDATA1, 32'h22);
    drain();

    // Store at head stalled by LSQ for three cycles.
    e0_i = store_e(); e1_i = mk(1'b0, 1'b1, 5'd2, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    st_commit_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push("ststall_comcnt", S_COMCNT, 0); push("ststall_valid", S_STV, 1);
      drain();
      cyc();
    end
    st_commit_ready_i = 1'b1;
    push("stgo_comcnt", S_COMCNT, 1); push("stgo_valid", S_STV, 1);
    drain();

    // Two stores: only one may retire.
    e1_i = store_e();
    push("st2_comcnt", S_COMCNT, 1); push("st2_valid", S_STV, 1);
    drain();

    // Store in slot1 behind an ALU op.
    e0_i = alu(5'd9, 32'h9); st_commit_ready_i = 1'b0;
    push("st1wait_comcnt", S_COMCNT, 1); push("st1wait_valid", S_STV, 1);
    drain();
    st_commit_ready_i = 1'b1;
    push("st1go_comcnt", S_COMCNT, 2);
    drain();

    // Exception on slot1: retire e0 only, no flush.
    e1_i = mk(1'b1, 1'b1, 5'd4, 32'h4, 1'b0, 1'b0, 1'b1, 32'h44, 32'h0);
    push("e1exc_comcnt", S_COMCNT, 1); push("e1exc_we1", S_WE1, 0);
    drain();
    cyc();
    push("e1exc_noflush", S_FLUSH, 0);
    drain();

    // Slot1 mispredict with head wrapping.
    head_i = 5'd31; e0_i = alu(5'd1, 32'h1);
    e1_i = mk(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h400);
    push("mp1_comcnt", S_COMCNT, 2); push("mp1_ridx1", S_RIDX1, 0);
    drain();
    cyc();
    push("mp1_flush", S_FLUSH, 1); push("mp1_fidx", S_FIDX, 1); push("mp1_redir", S_REDIR, 32'h400);
    push("mp1_fl_comcnt", S_COMCNT, 0);
    drain();
    cyc();
    e1_i = alu(5'd2, 32'h2);
    push("mp1_pulse_end", S_FLUSH, 0); push("mp1_rec_comcnt", S_COMCNT, 0);
    push("mp1_hold_fidx", S_FIDX, 1);
    drain();
    cyc();
    flush_ack_i = 1'b1;
    push("mp1_rec2_comcnt", S_COMCNT, 0);
    drain();
    cyc();
    flush_ack_i = 1'b0;
    push("mp1_run_comcnt", S_COMCNT, 2);
    drain();

    // Slot0 mispredict: retire e0 only.
    head_i = 5'd20;
    e0_i = mk(1'b1, 1'b1, 5'd6, 32'h66, 1'b0, 1'b1, 1'b0, 32'h0, 32'h1234);
    push("mp0_comcnt", S_COMCNT, 1); push("mp0_we0", S_WE0, 1); push("mp0_we1", S_WE1, 0);
    drain();
    cyc();
    push("mp0_flush", S_FLUSH, 1); push("mp0_fidx", S_FIDX, 21); push("mp0_redir", S_REDIR, 32'h1234);
    drain();
    cyc();
    flush_ack_i = 1'b1;
    cyc();
    flush_ack_i = 1'b0;
    e0_i = alu(5'd1, 32'h1);

    // Exception at head; ack during FLUSH must be ignored; reset in RECOVER.
    head_i = 5'd9; e0_i = mk(1'b1, 1'b1, 5'd1, 32'h1, 1'b0, 1'b0, 1'b1, 32'h80, 32'h0);
    push("exc_comcnt", S_COMCNT, 0); push("exc_we0", S_WE0, 0); push("exc_valid", S_STV, 0);
    drain();
    cyc();
    flush_ack_i = 1'b1; e0_i = alu(5'd1, 32'h1);
    push("exc_flush", S_FLUSH, 1); push("exc_fidx", S_FIDX, 9); push("exc_redir", S_REDIR, 32'h80);
    push("exc_fl_comcnt", S_COMCNT, 0);
    drain();
    cyc();
    flush_ack_i = 1'b0;
    push("exc_ackign_comcnt", S_COMCNT, 0); push("exc_rec_flush", S_FLUSH, 0);
    drain();
    rst_n = 1'b0;
    push("rstrec_flush", S_FLUSH, 0); push("rstrec_comcnt", S_COMCNT, 2);
    push("rstrec_fidx", S_FIDX, 0); push("rstrec_redir", S_REDIR, 0);
    drain();
    cyc();
    rst_n = 1'b1;
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
